bus_ram_param: RTL and testbench
================================

Name: bus_ram_param

Overview:
- Parametrised successor to the 16-byte bus RAM slave.
- Same Cmd/RW/Finish single-transaction bus protocol.
- Adds configurable base address, depth, mirrored decode window and programmable wait states.
- Sits on the CPU data bus as a generic RAM slave, e.g. 2 KB work RAM mirrored across 0x0000-0x1FFF.

Parameters:
- BASE_ADDR, 16'h0000, window base; only bits [15:WIN_BITS] are compared.
- ADDR_BITS, 4, log2 of storage depth in bytes (legal 1..WIN_BITS).
- WIN_BITS, 4, log2 of decoded window size (legal ADDR_BITS..15); WIN_BITS > ADDR_BITS gives mirroring.
- WAIT_CYCLES, 0, extra cycles between command capture and access (legal 0..15).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Addr  in  16  bus address.
- WData  in  8  write data.
- RData  out  8  read data; holds the last read value.
- Cmd  in  1  transaction request, sampled in IDLE only.
- RW  in  1  1 = write, 0 = read.
- Finish  out  1  one-cycle completion pulse.
- Err  out  1  parity error flag, valid with Finish.

Behaviour:
- Hit = Cmd & (Addr[15:WIN_BITS] == BASE_ADDR[15:WIN_BITS]).
- Memory index = Addr[ADDR_BITS-1:0]; bits [WIN_BITS-1:ADDR_BITS] are ignored (mirror).
- Reset values: state IDLE, Finish 0, Err 0, RData 8'h00, wait counter 0. Memory contents are not reset.
- States:
  - IDLE: on Hit, latch index, WData and RW.
    - If WAIT_CYCLES == 0: perform the access this edge, assert Finish, go to DONE.
    - Otherwise load the counter with WAIT_CYCLES-1 and go to WAIT.
    - A miss leaves the block silent: no Finish, no state change.
  - WAIT: decrement the counter. When it reads 0, perform the access from the latched values, assert Finish, go to DONE.
  - DONE: Finish and Err return to 0; go to IDLE. Cmd is not sampled in DONE.
- Latency: Cmd sampled at edge N gives Finish high for the single cycle after edge N+WAIT_CYCLES.
- Throughput: at most one transaction per WAIT_CYCLES+2 cycles.
- Write: mem[index] <= latched WData; RData unchanged.
- Read: RData <= mem[index], updated on the same edge that raises Finish.
- Addr, WData, RW and Cmd changes during WAIT or DONE are ignored.
- Cmd held high continuously starts a new transaction on every IDLE visit. The master must drop Cmd on seeing Finish.
- rst in any state: return to IDLE, Finish 0. A write still in WAIT is not committed. A write committed on the same edge as rst is not required to be blocked.
- Reading a never-written location returns undefined data.

Optional Feature:
- Macro: BUS_RAM_PARITY_EN.
- Defined:
  - Each entry stores 9 bits; on write, bit 8 <= ^WData.
  - On read, Err <= (^data[7:0] != stored parity), registered together with Finish. RData still returns the stored byte.
  - Err is high only in the Finish cycle.
- Undefined: 8-bit storage, Err tied to 0.

Decomposition:
- Package bus_ram_pkg:
  - state typedef {S_IDLE, S_WAIT, S_DONE};
  - RW_WRITE = 1, RW_READ = 0;
  - bus address width constant 16.
- Sub-module bus_ram_array: synchronous storage, one write or read port, width 8 or 9 chosen by the macro, depth 2**ADDR_BITS. The FSM, decode and counter stay in bus_ram_param.

Test Plan:
- Defaults: write 8'hA5 to 0x0003, then read 0x0003 → Finish one cycle after Cmd each time; RData = 8'hA5; Err = 0.
- BASE_ADDR = 16'h0000, ADDR_BITS = 11, WIN_BITS = 13: write 8'h3C to 0x0805, read 0x1805 → 8'h3C. Read 0x2005 → no Finish within 20 cycles.
- WAIT_CYCLES = 3: read issued at edge N → Finish exactly in the cycle after edge N+3. WData/Addr changed during WAIT have no effect.
- WAIT_CYCLES = 5: write 8'h11 to 0x0004, assert rst during WAIT → no Finish. A subsequent read of 0x0004 returns the prior value 8'h77.
- Cmd held high for 10 cycles with WAIT_CYCLES = 0 → Finish pulses every 2nd cycle, never two consecutive cycles high.
- BUS_RAM_PARITY_EN: write 8'h0F, force flip of stored bit 0, read → RData = 8'h0E and Err = 1 in the Finish cycle only. Without the macro, Err = 0 throughout.

Source files
------------

// File: rtl/bus_ram_pkg.sv
// Shared types and constants for the parametrised bus RAM slave.
package bus_ram_pkg;

    localparam int unsigned BUS_AW = 16;
    localparam int unsigned DATA_W = 8;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    // Captured transaction payload (index travels separately: its width is a parameter)
    typedef struct packed {
        logic              rw;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    function automatic logic parity8(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/bus_ram_array.sv
// Byte-addressed storage for bus_ram_param: synchronous write, combinational read.
// Width is 8 bits, or 9 when BUS_RAM_PARITY_EN adds a stored parity bit.
module bus_ram_array #(
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rd_data_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    logic [WIDTH-1:0] mem [DEPTH];

    // Single shared port: write on we, read data always reflects addr
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rd_data_c = mem[addr];

endmodule

// File: rtl/bus_ram_param.sv
// Parametrised RAM slave on the Cmd/RW/Finish bus: base/window decode with
// mirroring, programmable wait states, one transaction per WAIT_CYCLES+2 cycles.
// Optional macro BUS_RAM_PARITY_EN stores a parity bit per byte and flags Err on read.
module bus_ram_param
    import bus_ram_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int unsigned ADDR_BITS   = 4,
    parameter int unsigned WIN_BITS    = 4,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BUS_AW-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic [DATA_W-1:0] RData,
    input  logic              Cmd,
    input  logic              RW,
    output logic              Finish,
    output logic              Err
);

    localparam int unsigned CNT_W = 4;
`ifdef BUS_RAM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    bus_req_t             req_q;
    logic [ADDR_BITS-1:0] idx_q;

    logic                 hit_c;
    logic                 latch_c;
    logic                 acc_c;
    bus_req_t             acc_req_c;
    logic [ADDR_BITS-1:0] acc_idx_c;
    logic                 finish_d;
    logic                 err_d;
    logic                 we_c;
    logic                 rd_en_c;
    logic [MEM_W-1:0]     mem_wdata_c;
    logic [MEM_W-1:0]     rd_c;

    // Mirror bits between ADDR_BITS and WIN_BITS are deliberately don't-care
    logic unused_addr_c;
    assign unused_addr_c = ^Addr;

    // Window decode: only bits above WIN_BITS participate
    assign hit_c = Cmd && (Addr[BUS_AW-1:WIN_BITS] == BASE_ADDR[BUS_AW-1:WIN_BITS]);

    // State and wait-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, access strobe and access source (live bus or latched request)
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_c   = 1'b0;
        acc_c     = 1'b0;
        acc_req_c = req_q;
        acc_idx_c = idx_q;
        finish_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hit_c) begin
                    latch_c = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        acc_c           = 1'b1;
                        acc_req_c.rw    = RW;
                        acc_req_c.wdata = WData;
                        acc_idx_c       = Addr[ADDR_BITS-1:0];
                        finish_d        = 1'b1;
                        state_d         = S_DONE;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    acc_c    = 1'b1;
                    finish_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Capture the request so bus changes during WAIT/DONE have no effect
    always_ff @(posedge clk) begin
        if (latch_c) begin
            req_q.rw    <= RW;
            req_q.wdata <= WData;
            idx_q       <= Addr[ADDR_BITS-1:0];
        end
    end

    assign we_c    = acc_c && (acc_req_c.rw == RW_WRITE) && !rst;
    assign rd_en_c = acc_c && (acc_req_c.rw == RW_READ);

`ifdef BUS_RAM_PARITY_EN
    assign mem_wdata_c = {parity8(acc_req_c.wdata), acc_req_c.wdata};
    assign err_d       = rd_en_c && (parity8(rd_c[DATA_W-1:0]) != rd_c[DATA_W]);
`else
    assign mem_wdata_c = acc_req_c.wdata;
    assign err_d       = 1'b0;
`endif

    bus_ram_array #(
        .ADDR_BITS (ADDR_BITS),
        .WIDTH     (MEM_W)
    ) u_array (
        .clk       (clk),
        .we        (we_c),
        .addr      (acc_idx_c),
        .wdata     (mem_wdata_c),
        .rd_data_c (rd_c)
    );

    // Registered bus outputs; RData holds the last read value
    always_ff @(posedge clk) begin
        if (rst) begin
            Finish <= 1'b0;
            Err    <= 1'b0;
            RData  <= '0;
        end else begin
            Finish <= finish_d;
            Err    <= err_d;
            if (rd_en_c) begin
                RData <= rd_c[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_bus_ram_param.sv
// Directed bench for bus_ram_param: four configurations (default, mirrored
// 2 KB in 8 KB window, 3 wait states, 5 wait states) share one bus.
module tb_bus_ram_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rw;
    logic [3:0]  cmd;
    logic [3:0]  fin;
    logic [3:0]  err;
    logic [7:0]  rdata [4];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    bus_ram_param dut_a (
        .clk(clk), .rst(rst), .Addr(addr), .WData(wdata), .RData(rdata[0]),
        .Cmd(cmd[0]), .RW(rw), .Finish(fin[0]), .Err(err[0])
    );

    bus_ram_param #(.BASE_ADDR(16'h0000), .ADDR_BITS(11), .WIN_BITS(13)) dut_b (
        .clk(clk), .rst(rst), .Addr(addr), .WData(wdata), .RData(rdata[1]),
        .Cmd(cmd[1]), .RW(rw), .Finish(fin[1]), .Err(err[1])
    );

    bus_ram_param #(.WAIT_CYCLES(3)) dut_c (
        .clk(clk), .rst(rst), .Addr(addr), .WData(wdata), .RData(rdata[2]),
        .Cmd(cmd[2]), .RW(rw), .Finish(fin[2]), .Err(err[2])
    );

    bus_ram_param #(.WAIT_CYCLES(5)) dut_d (
        .clk(clk), .rst(rst), .Addr(addr), .WData(wdata), .RData(rdata[3]),
        .Cmd(cmd[3]), .RW(rw), .Finish(fin[3]), .Err(err[3])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction on DUT d; checks latency, Err and the single-cycle pulse.
    // With scramble set, the bus is disturbed every cycle while the DUT waits.
    task automatic run_txn(input int d, input logic is_wr, input logic [15:0] a,
                           input logic [7:0] wd, input int exp_lat, input logic exp_err,
                           input logic scramble, output logic [7:0] rd);
        int k;
        @(negedge clk);
        addr   = a;
        wdata  = wd;
        rw     = is_wr;
        cmd[d] = 1'b1;
        @(posedge clk);
        #1 cmd[d] = 1'b0;
        k = 0;
        while (k <= 40) begin
            @(negedge clk);
            if (fin[d]) break;
            if (scramble) begin
                addr  = 16'h0007;
                wdata = 8'hEE;
                rw    = ~is_wr;
            end
            k++;
        end
        check($sformatf("latency d%0d", d), 32'(k), 32'(exp_lat));
        check($sformatf("err_fin d%0d", d), 32'(err[d]), 32'(exp_err));
        rd = rdata[d];
        @(negedge clk);
        check($sformatf("fin_pulse d%0d", d), 32'(fin[d]), 32'd0);
        check($sformatf("err_clear d%0d", d), 32'(err[d]), 32'd0);
    endtask

    initial begin
        logic [7:0] rd;
        int         nfin;

        rst   = 1'b1;
        cmd   = '0;
        addr  = '0;
        wdata = '0;
        rw    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_fin d%0d", i), 32'(fin[i]), 32'd0);
            check($sformatf("rst_err d%0d", i), 32'(err[i]), 32'd0);
            check($sformatf("rst_rdata d%0d", i), 32'(rdata[i]), 32'h00);
        end
        rst = 1'b0;

        // Default configuration: write then read back
        run_txn(0, 1'b1, 16'h0003, 8'hA5, 0, 1'b0, 1'b0, rd);
        run_txn(0, 1'b0, 16'h0003, 8'h00, 0, 1'b0, 1'b0, rd);
        check("a_read", 32'(rd), 32'hA5);

        // Mirrored window: alias 0x1805 of 0x0805
        run_txn(1, 1'b1, 16'h0805, 8'h3C, 0, 1'b0, 1'b0, rd);
        run_txn(1, 1'b0, 16'h1805, 8'h00, 0, 1'b0, 1'b0, rd);
        check("b_mirror", 32'(rd), 32'h3C);

        // Outside the window: Cmd held 20 cycles, no response
        @(negedge clk);
        addr   = 16'h2005;
        rw     = 1'b0;
        cmd[1] = 1'b1;
        nfin   = 0;
        repeat (20) begin
            @(negedge clk);
            nfin += int'(fin[1]);
        end
        cmd[1] = 1'b0;
        check("b_miss", 32'(nfin), 32'd0);

        // Three wait states with the bus disturbed during WAIT
        run_txn(2, 1'b1, 16'h0002, 8'h5A, 3, 1'b0, 1'b1, rd);
        run_txn(2, 1'b0, 16'h0002, 8'h00, 3, 1'b0, 1'b1, rd);
        check("c_read", 32'(rd), 32'h5A);

        // Five wait states: reset in WAIT drops the write
        run_txn(3, 1'b1, 16'h0004, 8'h77, 5, 1'b0, 1'b0, rd);
        @(negedge clk);
        addr   = 16'h0004;
        wdata  = 8'h11;
        rw     = 1'b1;
        cmd[3] = 1'b1;
        @(posedge clk);
        #1 cmd[3] = 1'b0;
        nfin = 0;
        repeat (2) begin
            @(negedge clk);
            nfin += int'(fin[3]);
        end
        rst = 1'b1;
        @(negedge clk);
        nfin += int'(fin[3]);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            nfin += int'(fin[3]);
        end
        check("d_rst_nofin", 32'(nfin), 32'd0);
        run_txn(3, 1'b0, 16'h0004, 8'h00, 5, 1'b0, 1'b0, rd);
        check("d_keep", 32'(rd), 32'h77);

        // Cmd held high: Finish every second cycle
        @(negedge clk);
        addr   = 16'h0003;
        rw     = 1'b0;
        cmd[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("hold_fin %0d", i), 32'(fin[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        cmd[0] = 1'b0;
        check("hold_rdata", 32'(rdata[0]), 32'hA5);
        @(negedge clk);

`ifdef BUS_RAM_PARITY_EN
        // Corrupt stored bit 0 of a parity-protected byte
        run_txn(0, 1'b1, 16'h0009, 8'h0F, 0, 1'b0, 1'b0, rd);
        dut_a.u_array.mem[9][0] = ~dut_a.u_array.mem[9][0];
        run_txn(0, 1'b0, 16'h0009, 8'h00, 0, 1'b1, 1'b0, rd);
        check("par_rdata", 32'(rd), 32'h0E);
`else
        run_txn(0, 1'b1, 16'h0009, 8'h0F, 0, 1'b0, 1'b0, rd);
        run_txn(0, 1'b0, 16'h0009, 8'h00, 0, 1'b0, 1'b0, rd);
        check("nopar_rdata", 32'(rd), 32'h0F);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
